// File: rtl/sram_mem_ctrl.sv
// Mem-stage data memory controller driving an external 16-bit asynchronous SRAM.
// Each 32-bit word takes two half-accesses of SRAM_WAIT cycles, low half first.
// ready stays low while an access is in flight so the pipeline can stall upstream.
// Optional feature: define SRAM_READ_BUF_EN for a single-entry read buffer that
// lets a repeated read of the last loaded word complete in its IDLE cycle.
module sram_mem_ctrl #(
  parameter int unsigned SRAM_WAIT = 5,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);
  localparam logic [3:0]  LastCnt  = 4'(SRAM_WAIT - 1);
  // Strobe is released one cycle early so data is held past the rising edge of we_n.
  localparam logic [3:0]  WeOffCnt = 4'(SRAM_WAIT - 2);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [16:0] word_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic [31:0] read_data_q;
  logic [17:0] sram_addr_q;
  logic        sram_we_n_q;
  logic [15:0] sram_dq_o_q;
  logic        sram_dq_oe_q;

  logic [31:0] off;
  logic        req;
  logic        buf_hit;
  logic        start;
  logic        unused_off;

  assign off        = address - BaseAddr;
  assign req        = rd_en | wr_en;
  assign start      = req & ~buf_hit;
  // Byte offset within the word and bits beyond the SRAM range are don't-care.
  assign unused_off = ^{off[31:19], off[1:0]};

`ifdef SRAM_READ_BUF_EN
  logic        buf_valid_q;
  logic [16:0] buf_tag_q;

  assign buf_hit = buf_valid_q & rd_en & ~wr_en & (buf_tag_q == off[18:2]);

  // Read buffer: loaded by every completed read, invalidated by any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
    end else if (state_q == StIdle && wr_en) begin
      buf_valid_q <= 1'b0;
    end else if (state_q == StHi && cnt_q == LastCnt && !wr_q) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= word_q;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // Access sequencer with registered SRAM bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      word_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      read_data_q  <= '0;
      sram_addr_q  <= '0;
      sram_we_n_q  <= 1'b1;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StLo;
            cnt_q        <= '0;
            word_q       <= off[18:2];
            data_q       <= write_data;
            wr_q         <= wr_en;
            sram_addr_q  <= {off[18:2], 1'b0};
            sram_dq_o_q  <= write_data[15:0];
            sram_dq_oe_q <= wr_en;
            sram_we_n_q  <= ~wr_en;
          end
        end
        StLo: begin
          if (cnt_q == LastCnt) begin
            if (!wr_q) read_data_q[15:0] <= sram_dq_i;
            state_q     <= StHi;
            cnt_q       <= '0;
            sram_addr_q <= {word_q, 1'b1};
            sram_dq_o_q <= data_q[31:16];
            sram_we_n_q <= ~wr_q;
          end else begin
            cnt_q       <= cnt_q + 4'd1;
            sram_we_n_q <= ~(wr_q & (cnt_q < WeOffCnt));
          end
        end
        StHi: begin
          if (cnt_q == LastCnt) begin
            if (!wr_q) read_data_q[31:16] <= sram_dq_i;
            state_q      <= StDone;
            cnt_q        <= '0;
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
          end else begin
            cnt_q       <= cnt_q + 4'd1;
            sram_we_n_q <= ~(wr_q & (cnt_q < WeOffCnt));
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stall is combinational so the request cycle itself already freezes upstream.
  always_comb begin
    ready = (state_q == StDone) | ((state_q == StIdle) & (~req | buf_hit));
  end

  assign read_data  = read_data_q;
  assign sram_addr  = sram_addr_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a behavioural 16-bit SRAM (64 halfwords).
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [0:63] = '{8: 16'h0BAD, 9: 16'hF00D, default: 16'h0000};
  logic [17:0] trace_addr [0:127];
  logic        trace_we   [0:127];

  sram_mem_ctrl #(
    .SRAM_WAIT(5),
    .BASE_ADDR(1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: array read, write while strobe low and bus driven.
  assign sram_dq_i = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One access from its IDLE cycle (cycle 0) up to the first cycle with ready high.
  // low_cycles counts cycles with ready low; drop_after >= 0 withdraws the enables.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int drop_after,
                            output int low_cycles, output logic [31:0] rdata);
    int  k;
    bit  done;
    k          = 0;
    done       = 1'b0;
    low_cycles = 0;
    @(posedge clk);
    #1;
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = data;
    while (!done && k < 100) begin
      @(negedge clk);
      trace_addr[k] = sram_addr;
      trace_we[k]   = sram_we_n;
      if (ready) begin
        done = 1'b1;
      end else begin
        low_cycles++;
        if (k == drop_after) begin
          rd_en = 1'b0;
          wr_en = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (!done) check_eq("access_timeout", 32'(k), 32'd0);
    rdata = read_data;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  int          cyc;
  logic [31:0] rd;
  int          we_low;

  initial begin
    // Reset state
    #12;
    check_eq("rst_read_data", read_data, 32'h0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_we_n", 32'(sram_we_n), 32'h1);
    check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // Write then read
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1, cyc, rd);
    check_eq("wr1024_cycles", 32'(cyc), 32'd11);
    check_eq("wr1024_rd_unchanged", rd, 32'h0);
    check_eq("wr1024_mem0", 32'(mem[0]), 32'h0000BEEF);
    check_eq("wr1024_mem1", 32'(mem[1]), 32'h0000DEAD);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, -1, cyc, rd);
    check_eq("rd1024_cycles", 32'(cyc), 32'd11);
    check_eq("rd1024_data", rd, 32'hDEADBEEF);

    // Address map and write strobe shape
    run_access(1'b0, 1'b1, 32'd1032, 32'h12345678, -1, cyc, rd);
    check_eq("wr1032_cycles", 32'(cyc), 32'd11);
    check_eq("wr1032_lo_addr_first", 32'(trace_addr[1]), 32'd4);
    check_eq("wr1032_lo_addr_last", 32'(trace_addr[5]), 32'd4);
    check_eq("wr1032_hi_addr_first", 32'(trace_addr[6]), 32'd5);
    check_eq("wr1032_hi_addr_last", 32'(trace_addr[10]), 32'd5);
    we_low = 0;
    for (int i = 1; i <= 5; i++) if (!trace_we[i]) we_low++;
    check_eq("wr1032_lo_we_low", 32'(we_low), 32'd4);
    check_eq("wr1032_lo_we_last", 32'(trace_we[5]), 32'd1);
    we_low = 0;
    for (int i = 6; i <= 10; i++) if (!trace_we[i]) we_low++;
    check_eq("wr1032_hi_we_low", 32'(we_low), 32'd4);
    check_eq("wr1032_hi_we_last", 32'(trace_we[10]), 32'd1);
    check_eq("wr1032_mem4", 32'(mem[4]), 32'h00005678);
    check_eq("wr1032_mem5", 32'(mem[5]), 32'h00001234);

    // Simultaneous enables act as a write
    run_access(1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, -1, cyc, rd);
    check_eq("both_cycles", 32'(cyc), 32'd11);
    check_eq("both_rd_unchanged", rd, 32'hDEADBEEF);
    check_eq("both_mem2", 32'(mem[2]), 32'h0000A5A5);
    check_eq("both_mem3", 32'(mem[3]), 32'h0000A5A5);

    // Reset mid-access in cycle 3 of LO during a write
    @(posedge clk);
    #1;
    wr_en      = 1'b1;
    address    = 32'd1036;
    write_data = 32'h11112222;
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_we_low_before_rst", 32'(sram_we_n), 32'h0);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    check_eq("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    check_eq("mid_rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    check_eq("mid_rst_addr", 32'(sram_addr), 32'h0);
    check_eq("mid_rst_dq_o", 32'(sram_dq_o), 32'h0);
    check_eq("mid_rst_read_data", read_data, 32'h0);
    check_eq("mid_rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, -1, cyc, rd);
    check_eq("post_rst_cycles", 32'(cyc), 32'd11);
    check_eq("post_rst_data", rd, 32'hDEADBEEF);

    // Request withdrawn after cycle 1
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1, cyc, rd);
    check_eq("withdrawn_cycles", 32'(cyc), 32'd11);
    check_eq("withdrawn_data", rd, 32'h12345678);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("withdrawn_idle_ready", 32'(ready), 32'h1);

    // Repeated read, then write, then read of 1040
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, -1, cyc, rd);
    check_eq("rd1040_first_cycles", 32'(cyc), 32'd11);
    check_eq("rd1040_first_data", rd, 32'hF00D0BAD);
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, -1, cyc, rd);
`ifdef SRAM_READ_BUF_EN
    check_eq("rd1040_second_cycles", 32'(cyc), 32'd0);
`else
    check_eq("rd1040_second_cycles", 32'(cyc), 32'd11);
`endif
    check_eq("rd1040_second_data", rd, 32'hF00D0BAD);
    run_access(1'b0, 1'b1, 32'd1040, 32'h13579BDF, -1, cyc, rd);
    check_eq("wr1040_cycles", 32'(cyc), 32'd11);
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, -1, cyc, rd);
    check_eq("rd1040_after_wr_cycles", 32'(cyc), 32'd11);
    check_eq("rd1040_after_wr_data", rd, 32'h13579BDF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
